// File: rtl/led_status_sequencer_pkg.sv
// rtl/led_status_sequencer_pkg.sv - shared types, defaults and helpers for the LED status sequencer
package led_seq_pkg;

  // Pattern source currently owning the LEDs, highest priority last
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FLASH, ST_ERROR} led_state_e;

  // Error blink-code phases
  localparam logic [1:0] EP_ON  = 2'd0;
  localparam logic [1:0] EP_OFF = 2'd1;
  localparam logic [1:0] EP_GAP = 2'd2;

  // Default timing in ms ticks
  localparam int HEART_MS_DEF    = 500;
  localparam int FAST_MS_DEF     = 125;
  localparam int FLASH_MS_DEF    = 100;
  localparam int CODE_ON_MS_DEF  = 200;
  localparam int CODE_GAP_MS_DEF = 1000;

  // Bits needed to hold 0..max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int PULSE_W = cnt_w(8);

  // Error code 0 blinks eight times, any other code blinks its own value
  function automatic logic [PULSE_W-1:0] code_to_pulses(input logic [2:0] code);
    return (code == 3'd0) ? PULSE_W'(8) : PULSE_W'(code);
  endfunction

endpackage

// File: rtl/led_status_sequencer_if.sv
// rtl/led_status_sequencer_if.sv - event inputs and LED outputs of the status sequencer
interface led_status_sequencer_if;
  logic       iBusy;
  logic       iEvtCapture;
  logic       iEvtError;
  logic [2:0] iErrCode;
  logic       iErrClr;
  logic       oLED1;
  logic       oLED2;
  logic       oErrActive;

  modport master (
    output iBusy, iEvtCapture, iEvtError, iErrCode, iErrClr,
    input  oLED1, oLED2, oErrActive
  );

  modport slave (
    input  iBusy, iEvtCapture, iEvtError, iErrCode, iErrClr,
    output oLED1, oLED2, oErrActive
  );
endinterface

// File: rtl/led_status_sequencer_tick_gen.sv
// rtl/led_status_sequencer_tick_gen.sv - prescaler emitting a one-cycle tick at TICK_HZ
module led_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // A divide-by-one build leaves the counter parked at 0, so every cycle ticks
  assign tick_o = (cnt_q == TERM);

  // Count 0..DIV-1 and wrap on the tick
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + W'(1);
  end

  // Prescaler register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_status_sequencer.sv
// rtl/led_status_sequencer.sv - prioritised status blink patterns on two LEDs (optional LED_PWM_DIM_EN dimming)
module led_status_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int HEART_MS    = HEART_MS_DEF,
  parameter int FAST_MS     = FAST_MS_DEF,
  parameter int FLASH_MS    = FLASH_MS_DEF,
  parameter int CODE_ON_MS  = CODE_ON_MS_DEF,
  parameter int CODE_GAP_MS = CODE_GAP_MS_DEF
) (
  input  logic                  iClk,
  input  logic                  iRst_N,
  led_status_sequencer_if.slave bus
);
  localparam int HB_W = cnt_w(HEART_MS - 1);
  localparam int FA_W = cnt_w(FAST_MS - 1);
  localparam int FL_W = cnt_w(FLASH_MS);
  localparam int ET_W = cnt_w(((CODE_ON_MS > CODE_GAP_MS) ? CODE_ON_MS : CODE_GAP_MS) - 1);
  localparam logic [HB_W-1:0] HB_T    = HB_W'(HEART_MS - 1);
  localparam logic [FA_W-1:0] FA_T    = FA_W'(FAST_MS - 1);
  localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLASH_MS);
  localparam logic [ET_W-1:0] ON_T    = ET_W'(CODE_ON_MS - 1);
  localparam logic [ET_W-1:0] GAP_T   = ET_W'(CODE_GAP_MS - 1);

  logic tick;
  logic [HB_W-1:0]    hb_cnt_q, hb_cnt_d;
  logic               hb_ph_q, hb_ph_d;
  logic [FA_W-1:0]    fa_cnt_q, fa_cnt_d;
  logic               fa_ph_q, fa_ph_d;
  logic [FL_W-1:0]    flash_q, flash_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;
  logic [1:0]         eph_q, eph_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [ET_W-1:0]    etmr_q, etmr_d;
  logic               led1_q, led1_d, led2_q, led2_d;
  led_state_e         state_d;

  led_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk_i (iClk),
    .rst_ni(iRst_N),
    .tick_o(tick)
  );

  // Heartbeat and busy phases run in every state so patterns resume without a jump
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    hb_ph_d  = hb_ph_q;
    fa_cnt_d = fa_cnt_q;
    fa_ph_d  = fa_ph_q;
    if (tick) begin
      if (hb_cnt_q == HB_T) begin
        hb_cnt_d = '0;
        hb_ph_d  = ~hb_ph_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_W'(1);
      end
      if (fa_cnt_q == FA_T) begin
        fa_cnt_d = '0;
        fa_ph_d  = ~fa_ph_q;
      end else begin
        fa_cnt_d = fa_cnt_q + FA_W'(1);
      end
    end
  end

  // Capture flash: (re)load on an event unless an error is latched or arriving
  always_comb begin
    flash_d = flash_q;
    if (bus.iEvtCapture && !err_q && !bus.iEvtError) flash_d = FL_LOAD;
    else if (tick && flash_q != '0)                  flash_d = flash_q - FL_W'(1);
  end

  // Error latch and blink-code burst; a new error beats a simultaneous clear
  always_comb begin
    err_d   = err_q;
    code_d  = code_q;
    eph_d   = eph_q;
    pulse_d = pulse_q;
    etmr_d  = etmr_q;
    if (bus.iEvtError || bus.iErrClr) begin
      err_d   = bus.iEvtError;
      code_d  = bus.iEvtError ? bus.iErrCode : code_q;
      eph_d   = EP_ON;
      pulse_d = '0;
      etmr_d  = '0;
    end else if (err_q && tick) begin
      etmr_d = etmr_q + ET_W'(1);
      case (eph_q)
        EP_ON: if (etmr_q == ON_T) begin
          etmr_d  = '0;
          eph_d   = EP_OFF;
          pulse_d = pulse_q + PULSE_W'(1);
        end
        EP_OFF: if (etmr_q == ON_T) begin
          etmr_d = '0;
          eph_d  = (pulse_q == code_to_pulses(code_q)) ? EP_GAP : EP_ON;
        end
        default: if (etmr_q == GAP_T) begin
          etmr_d  = '0;
          eph_d   = EP_ON;
          pulse_d = '0;
        end
      endcase
    end
  end

  // Pick the owning pattern from next-state values so outputs land with the state change
  always_comb begin
    if (err_d)               state_d = ST_ERROR;
    else if (flash_d != '0)  state_d = ST_FLASH;
    else if (bus.iBusy)      state_d = ST_BUSY;
    else                     state_d = ST_IDLE;
    led1_d = hb_ph_d;
    led2_d = ~hb_ph_d;
    case (state_d)
      ST_ERROR: begin
        led1_d = (eph_d == EP_ON);
        led2_d = (eph_d == EP_ON);
      end
      ST_FLASH: begin
        led1_d = bus.iBusy ? fa_ph_d : hb_ph_d;
        led2_d = 1'b1;
      end
      ST_BUSY: begin
        led1_d = fa_ph_d;
        led2_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      hb_cnt_q <= '0;
      hb_ph_q  <= 1'b0;
      fa_cnt_q <= '0;
      fa_ph_q  <= 1'b0;
      flash_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      eph_q    <= EP_ON;
      pulse_q  <= '0;
      etmr_q   <= '0;
      led1_q   <= 1'b0;
      led2_q   <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_ph_q  <= hb_ph_d;
      fa_cnt_q <= fa_cnt_d;
      fa_ph_q  <= fa_ph_d;
      flash_q  <= flash_d;
      err_q    <= err_d;
      code_q   <= code_d;
      eph_q    <= eph_d;
      pulse_q  <= pulse_d;
      etmr_q   <= etmr_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
    end
  end

  assign bus.oErrActive = err_q;

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_cnt_q;
  logic       pwm_gate;

  // Free-running dimming counter, LEDs lit for 4 of every 16 cycles
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) pwm_cnt_q <= '0;
    else         pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end

  assign pwm_gate  = (pwm_cnt_q < 4'd4);
  assign bus.oLED1 = led1_q & pwm_gate;
  assign bus.oLED2 = led2_q & pwm_gate;
`else
  assign bus.oLED1 = led1_q;
  assign bus.oLED2 = led2_q;
`endif
endmodule

// File: tb/tb_led_status_sequencer.sv
// tb/tb_led_status_sequencer.sv - scoreboard bench for led_status_sequencer at one tick per cycle
module tb_led_status_sequencer;
  typedef struct {
    int    at;
    logic  l1;
    logic  l2;
    logic  ea;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;

  led_status_sequencer_if bus();

  led_status_sequencer #(.CLK_HZ(1000), .TICK_HZ(1000)) dut (
    .iClk  (clk),
    .iRst_N(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic push(input int at, input logic l1, input logic l2, input logic ea, input string name);
    exp_t e;
    e.at = at; e.l1 = l1; e.l2 = l2; e.ea = ea; e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_edges(input int k);
    while (edges < k) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic pulse_err(input logic [2:0] code, input logic clr);
    bus.iEvtError = 1'b1; bus.iErrCode = code; bus.iErrClr = clr;
    @(negedge clk);
    bus.iEvtError = 1'b0; bus.iErrCode = 3'd0; bus.iErrClr = 1'b0;
  endtask

  task automatic pulse_cap();
    bus.iEvtCapture = 1'b1;
    @(negedge clk);
    bus.iEvtCapture = 1'b0;
  endtask

  // Monitor: compare the head expectation when its edge comes round
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].at < edges) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", q[0].name, q[0].at, edges);
        q.delete(0);
      end
      if (q.size() > 0 && q[0].at == edges) begin
        cur = q[0];
        q.delete(0);
        checks++;
        if ({bus.oLED1, bus.oLED2, bus.oErrActive} !== {cur.l1, cur.l2, cur.ea}) begin
          errors++;
          $display("FAIL %s @%0d: got led1=%b led2=%b err=%b expected led1=%b led2=%b err=%b",
                   cur.name, edges, bus.oLED1, bus.oLED2, bus.oErrActive, cur.l1, cur.l2, cur.ea);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bus.iBusy = 1'b0; bus.iEvtCapture = 1'b0; bus.iEvtError = 1'b0;
    bus.iErrCode = 3'd0; bus.iErrClr = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_now("reset_led1", bus.oLED1, 1'b0);
    check_now("reset_led2", bus.oLED2, 1'b0);
    check_now("reset_err", bus.oErrActive, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    push(1, 0, 1, 0, "idle_first");
    push(499, 0, 1, 0, "idle_pre_toggle");
    push(500, 1, 0, 0, "idle_toggle1");
    push(999, 1, 0, 0, "idle_hold");
    push(1000, 0, 1, 0, "idle_toggle2");

    wait_edges(1050);
    push(1101, 0, 0, 0, "busy_enter");
    push(1124, 0, 0, 0, "busy_pre_toggle");
    push(1125, 1, 0, 0, "busy_toggle1");
    push(1249, 1, 0, 0, "busy_hold");
    push(1250, 0, 0, 0, "busy_toggle2");
    push(1301, 0, 1, 0, "busy_exit_phase");
    push(1499, 0, 1, 0, "idle_resume_hold");
    push(1500, 1, 0, 0, "idle_resume_toggle");
    wait_edges(1100); bus.iBusy = 1'b1;
    wait_edges(1300); bus.iBusy = 1'b0;

    push(1600, 1, 0, 0, "flash_before");
    push(1601, 1, 1, 0, "flash_start");
    push(1700, 1, 1, 0, "flash_mid");
    push(1701, 1, 1, 0, "flash_retrigger_hold");
    push(1750, 1, 1, 0, "flash_last");
    push(1751, 1, 0, 0, "flash_end");
    wait_edges(1600); pulse_cap();
    wait_edges(1650); pulse_cap();

    push(2000, 0, 1, 0, "err3_before");
    push(2001, 1, 1, 1, "err3_on1");
    push(2200, 1, 1, 1, "err3_on1_end");
    push(2201, 0, 0, 1, "err3_off1");
    push(2401, 1, 1, 1, "err3_on2");
    push(3000, 1, 1, 1, "err3_on3_end");
    push(3001, 0, 0, 1, "err3_off3");
    push(3101, 0, 0, 1, "err3_capture_ignored");
    push(3150, 0, 0, 1, "err3_capture_ignored_late");
    push(3200, 0, 0, 1, "err3_off3_end");
    push(4200, 0, 0, 1, "err3_gap_end");
    push(4201, 1, 1, 1, "err3_repeat");
    wait_edges(2000); pulse_err(3'd3, 1'b0);
    wait_edges(3100); pulse_cap();

    push(4401, 1, 1, 1, "err0_restart_on");
    push(4501, 0, 0, 1, "err0_off1");
    push(7100, 0, 0, 1, "err0_off7");
    push(7101, 1, 1, 1, "err0_on8");
    push(7301, 0, 0, 1, "err0_off8");
    push(7500, 0, 0, 1, "err0_off8_end");
    push(8500, 0, 0, 1, "err0_gap_end");
    push(8501, 1, 1, 1, "err0_repeat");
    wait_edges(4300); pulse_err(3'd0, 1'b0);

    push(8601, 1, 1, 1, "err2_clr_race_on1");
    push(8800, 1, 1, 1, "err2_on1_end");
    push(8801, 0, 0, 1, "err2_off1");
    push(9001, 1, 1, 1, "err2_on2");
    push(9401, 0, 0, 1, "err2_gap_start");
    push(10400, 0, 0, 1, "err2_gap_end");
    push(10401, 1, 1, 1, "err2_repeat");
    wait_edges(8600); pulse_err(3'd2, 1'b1);

    push(10501, 1, 0, 0, "clr_idle");
    push(10999, 1, 0, 0, "clr_idle_hold");
    push(11000, 0, 1, 0, "clr_idle_toggle");
    push(11101, 1, 1, 1, "err1_on");
    wait_edges(10500);
    bus.iErrClr = 1'b1; @(negedge clk); bus.iErrClr = 1'b0;
    wait_edges(11100); pulse_err(3'd1, 1'b0);

    wait_edges(11150);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_now("async_reset_led1", bus.oLED1, 1'b0);
    check_now("async_reset_led2", bus.oLED2, 1'b0);
    check_now("async_reset_err", bus.oErrActive, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(1, 0, 1, 0, "post_reset_first");
    push(499, 0, 1, 0, "post_reset_hold");
    push(500, 1, 0, 0, "post_reset_toggle");
    wait_edges(501);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
